// File: rtl/threefish_pkg.sv
// Shared constants, FSM state type and helpers for the Threefish key schedule.
package threefish_pkg;

  localparam logic [63:0] C240 = 64'h1BD11BDAA9FC1A22;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_READY  = 2'd1,
    ST_STREAM = 2'd2
  } tf_state_e;

  function automatic bit nw_legal(input int nw);
    return (nw == 4) || (nw == 8) || (nw == 16);
  endfunction

  // Remainder by repeated compare-and-subtract; 11 steps cover 31 mod 3.
  function automatic logic [4:0] mod_small(input logic [4:0] v, input logic [4:0] m);
    logic [4:0] r;
    r = v;
    for (int n = 0; n < 11; n++) begin
      if (r >= m) r = r - m;
    end
    return r;
  endfunction

endpackage

// File: rtl/threefish_ks_word.sv
// One subkey word: selected key word plus the tweak/index term for word i.
module threefish_ks_word
  import threefish_pkg::*;
#(
  parameter int NW = 4,
  parameter int W  = 64
) (
  input  logic [W-1:0] k_word,
  input  logic [W-1:0] t_a,
  input  logic [W-1:0] t_b,
  input  logic [4:0]   s,
  input  logic [3:0]   i,
  output logic [W-1:0] word
);

  localparam logic [3:0] IDX_TA = 4'(NW - 3);
  localparam logic [3:0] IDX_TB = 4'(NW - 2);
  localparam logic [3:0] IDX_S  = 4'(NW - 1);

  // Sums wrap modulo 2^W; the carry is simply dropped.
  always_comb begin
    word = k_word;
    if (i == IDX_TA) begin
      word = k_word + t_a;
    end else if (i == IDX_TB) begin
      word = k_word + t_b;
    end else if (i == IDX_S) begin
      word = k_word + W'(s);
    end
  end

endmodule

// File: rtl/threefish_key_schedule.sv
// Threefish key schedule: loads key and tweak once, then streams subkeys on request.
module threefish_key_schedule
  import threefish_pkg::*;
#(
  parameter int NW          = 4,
  parameter int W           = 64,
  parameter int NUM_SUBKEYS = 19
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          load_valid_i,
  output logic          load_ready_o,
  input  logic [W-1:0]  load_word_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [4:0]    req_index_i,
  output logic          sk_valid_o,
  input  logic          sk_ready_i,
  output logic [W-1:0]  sk_word_o,
  output logic [3:0]    sk_word_idx_o,
  output logic          sk_last_o,
  output logic          err_o,
  output tf_state_e     state_o
);

  if (!nw_legal(NW)) begin : g_nw_check
    $error("threefish_key_schedule: NW must be 4, 8 or 16");
  end

  localparam int              KPW         = $clog2(NW + 1);
  localparam logic [KPW-1:0]  KP_MAX      = KPW'(NW);
  localparam logic [3:0]      LAST_IDX    = 4'(NW - 1);
  localparam logic [W-1:0]    PARITY_INIT = W'(C240);

  // Every channel transfers on a cycle where its valid and ready are both high;
  // valid must be held until that cycle and the payload must not change meanwhile.

  tf_state_e       state_q;
  logic [W-1:0]    k_q [NW+1];
  logic [W-1:0]    t_q [3];
  logic [KPW-1:0]  load_cnt_q;
  logic [4:0]      s_q;
  logic [KPW-1:0]  kp_q;
  logic [1:0]      tp0_q;
  logic [1:0]      tp1_q;

  logic            req_in_range;
  logic [KPW-1:0]  req_kp;
  logic [1:0]      req_tp0;
  logic [4:0]      nxt_s;
  logic [3:0]      nxt_i;
  logic [KPW-1:0]  nxt_kp;
  logic [1:0]      nxt_tp0;
  logic [1:0]      nxt_tp1;
  logic [W-1:0]    word_next;

  assign state_o      = state_q;
  assign req_in_range = int'({27'd0, req_index_i}) < NUM_SUBKEYS;

  always_comb begin
    req_kp  = KPW'(mod_small(req_index_i, 5'(NW + 1)));
    req_tp0 = 2'(mod_small(req_index_i, 5'd3));
  end

  // In READY the pointers come from the incoming index; in STREAM they advance by one word.
  always_comb begin
    nxt_s   = s_q;
    nxt_i   = sk_word_idx_o + 4'd1;
    nxt_kp  = (kp_q == KP_MAX) ? '0 : kp_q + KPW'(1);
    nxt_tp0 = tp0_q;
    nxt_tp1 = tp1_q;
    if (state_q == ST_READY) begin
      nxt_s   = req_index_i;
      nxt_i   = 4'd0;
      nxt_kp  = req_kp;
      nxt_tp0 = req_tp0;
      nxt_tp1 = (req_tp0 == 2'd2) ? 2'd0 : req_tp0 + 2'd1;
    end
  end

  threefish_ks_word #(
    .NW (NW),
    .W  (W)
  ) u_word (
    .k_word (k_q[nxt_kp]),
    .t_a    (t_q[nxt_tp0]),
    .t_b    (t_q[nxt_tp1]),
    .s      (nxt_s),
    .i      (nxt_i),
    .word   (word_next)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= ST_LOAD;
      for (int n = 0; n < NW; n++) k_q[n] <= '0;
      k_q[NW]       <= PARITY_INIT;
      for (int n = 0; n < 3; n++) t_q[n] <= '0;
      load_cnt_q    <= '0;
      s_q           <= '0;
      kp_q          <= '0;
      tp0_q         <= '0;
      tp1_q         <= '0;
      load_ready_o  <= 1'b1;
      req_ready_o   <= 1'b0;
      sk_valid_o    <= 1'b0;
      sk_word_o     <= '0;
      sk_word_idx_o <= '0;
      sk_last_o     <= 1'b0;
      err_o         <= 1'b0;
    end else if (clear_i) begin
      state_q       <= ST_LOAD;
      for (int n = 0; n < NW; n++) k_q[n] <= '0;
      k_q[NW]       <= PARITY_INIT;
      for (int n = 0; n < 3; n++) t_q[n] <= '0;
      load_cnt_q    <= '0;
      s_q           <= '0;
      kp_q          <= '0;
      tp0_q         <= '0;
      tp1_q         <= '0;
      load_ready_o  <= 1'b1;
      req_ready_o   <= 1'b0;
      sk_valid_o    <= 1'b0;
      sk_word_o     <= '0;
      sk_word_idx_o <= '0;
      sk_last_o     <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (load_valid_i && load_ready_o) begin
            load_cnt_q <= load_cnt_q + KPW'(1);
            if (load_cnt_q < KP_MAX) begin
              k_q[load_cnt_q] <= load_word_i;
              k_q[NW]         <= k_q[NW] ^ load_word_i;
            end else if (load_cnt_q == KP_MAX) begin
              t_q[0] <= load_word_i;
            end else begin
              t_q[1]       <= load_word_i;
              t_q[2]       <= t_q[0] ^ load_word_i;
              load_cnt_q   <= '0;
              state_q      <= ST_READY;
              load_ready_o <= 1'b0;
              req_ready_o  <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (req_valid_i && req_ready_o) begin
            if (req_in_range) begin
              state_q       <= ST_STREAM;
              req_ready_o   <= 1'b0;
              sk_valid_o    <= 1'b1;
              sk_word_o     <= word_next;
              sk_word_idx_o <= nxt_i;
              sk_last_o     <= (nxt_i == LAST_IDX);
              s_q           <= nxt_s;
              kp_q          <= nxt_kp;
              tp0_q         <= nxt_tp0;
              tp1_q         <= nxt_tp1;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (sk_valid_o && sk_ready_i) begin
            if (sk_last_o) begin
              state_q     <= ST_READY;
              sk_valid_o  <= 1'b0;
              req_ready_o <= 1'b1;
            end else begin
              sk_word_o     <= word_next;
              sk_word_idx_o <= nxt_i;
              sk_last_o     <= (nxt_i == LAST_IDX);
              kp_q          <= nxt_kp;
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_threefish_key_schedule.sv
// Bench for threefish_key_schedule with NW=4, W=64, NUM_SUBKEYS=19.
module tb_threefish_key_schedule;
  import threefish_pkg::*;

  localparam int NS = 19;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [63:0] load_word = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_index = '0;
  logic        sk_valid;
  logic        sk_ready = 1'b0;
  logic [63:0] sk_word;
  logic [3:0]  sk_word_idx;
  logic        sk_last;
  logic        err;
  tf_state_e   st;

  threefish_key_schedule #(.NW(4), .W(64), .NUM_SUBKEYS(NS)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clear),
    .load_valid_i  (load_valid),
    .load_ready_o  (load_ready),
    .load_word_i   (load_word),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_index_i   (req_index),
    .sk_valid_o    (sk_valid),
    .sk_ready_i    (sk_ready),
    .sk_word_o     (sk_word),
    .sk_word_idx_o (sk_word_idx),
    .sk_last_o     (sk_last),
    .err_o         (err),
    .state_o       (st)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required summary before 400000ns");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [3:0]  exp_idx_q[$];
  int sk_cnt = 0;
  int err_cnt = 0;
  bit in_reset = 1'b1;
  bit ready_toggle = 1'b0;
  bit ready_level = 1'b1;
  logic [3:0][63:0] cur_key;
  logic [1:0][63:0] cur_tw;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_word(input logic [3:0][63:0] key, input logic [1:0][63:0] tw,
                                             input int s, input int i);
    logic [63:0] kx[5];
    logic [63:0] tx[3];
    logic [63:0] r;
    kx[4] = C240;
    for (int j = 0; j < 4; j++) begin
      kx[j] = key[j];
      kx[4] = kx[4] ^ key[j];
    end
    tx[0] = tw[0];
    tx[1] = tw[1];
    tx[2] = tw[0] ^ tw[1];
    r = kx[(s + i) % 5];
    if (i == 1) r = r + tx[s % 3];
    if (i == 2) r = r + tx[(s + 1) % 3];
    if (i == 3) r = r + 64'(s);
    return r;
  endfunction

  task automatic push_model(input int s);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(model_word(cur_key, cur_tw, s, i));
      exp_idx_q.push_back(4'(i));
    end
  endtask

  // ---------------- sink ready driver ----------------
  always @(posedge clk) begin
    #1;
    if (ready_toggle) sk_ready = ~sk_ready;
    else sk_ready = ready_level;
  end

  // ---------------- output monitor ----------------
  bit          hold_v = 1'b0;
  logic [63:0] hold_w;
  logic [3:0]  hold_i;
  always @(negedge clk) begin
    logic [63:0] e;
    logic [3:0]  ei;
    if (!in_reset && hold_v) begin
      check("hold_valid", 64'(sk_valid), 64'(1));
      check("hold_word", sk_word, hold_w);
      check("hold_idx", 64'(sk_word_idx), 64'(hold_i));
    end
    hold_v = !in_reset && sk_valid && !sk_ready;
    hold_w = sk_word;
    hold_i = sk_word_idx;
    if (err) err_cnt++;
    if (sk_valid && sk_ready) begin
      sk_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h idx %0d, required no word", sk_word, sk_word_idx);
      end else begin
        e  = exp_q.pop_front();
        ei = exp_idx_q.pop_front();
        check("sk_word", sk_word, e);
        check("sk_idx", 64'(sk_word_idx), 64'(ei));
        check("sk_last", 64'(sk_last), 64'(ei == 4'd3));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs();
    check("rst_load_ready", 64'(load_ready), 64'(1));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_sk_valid", 64'(sk_valid), 64'(0));
    check("rst_sk_word", sk_word, 64'(0));
    check("rst_sk_idx", 64'(sk_word_idx), 64'(0));
    check("rst_sk_last", 64'(sk_last), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_state", 64'(st), 64'(ST_LOAD));
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic load_all(input logic [3:0][63:0] key, input logic [1:0][63:0] tw);
    bit ok;
    int b;
    cur_key = key;
    cur_tw  = tw;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      load_valid = 1'b1;
      load_word  = (n < 4) ? key[n] : tw[n-4];
      b = 0;
      do begin
        @(negedge clk);
        ok = load_ready;
        b++;
      end while (!ok && b < 50);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL load_timeout: got no load_ready for word %0d, required accept", n);
      end
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic request(input logic [4:0] s);
    bit ok;
    int b;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_index = s;
    b = 0;
    do begin
      @(negedge clk);
      ok = req_ready;
      b++;
    end while (!ok && b < 100);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL req_timeout: got no req_ready for s=%0d, required accept", s);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int b = 0; b < 200 && !done; b++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && req_ready;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: got %0d words pending, required 0 and req_ready", name, exp_q.size());
      exp_q.delete();
      exp_idx_q.delete();
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit               reload;
    logic [3:0][63:0] key;
    logic [1:0][63:0] tw;
    logic [4:0]       s;
    logic [3:0][63:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int base;
    int err0;
    bit hit;

    vecs[0] = '{1'b1, '0, '0, 5'd1, {64'h1BD11BDAA9FC1A23, 64'd0, 64'd0, 64'd0}};
    vecs[1] = '{1'b1, {64'd4, 64'd3, 64'd2, 64'd1}, {64'd6, 64'd5}, 5'd0,
                {64'd4, 64'd9, 64'd7, 64'd1}};
    vecs[2] = '{1'b0, {64'd4, 64'd3, 64'd2, 64'd1}, {64'd6, 64'd5}, 5'd5,
                {64'd9, 64'd8, 64'd5, 64'd1}};
    vecs[3] = '{1'b1, {64'hFFFFFFFFFFFFFFFF, 64'd0, 64'd0, 64'd0}, '0, 5'd2,
                {64'd2, 64'hE42EE4255603E5DD, 64'hFFFFFFFFFFFFFFFF, 64'd0}};
    vecs[4] = '{1'b0, {64'hFFFFFFFFFFFFFFFF, 64'd0, 64'd0, 64'd0}, '0, 5'd18,
                {64'h12, 64'd0, 64'hE42EE4255603E5DD, 64'hFFFFFFFFFFFFFFFF}};

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b1;
    in_reset = 1'b0;
    @(negedge clk);
    check_reset_outputs();

    // table vectors; entries without reload reuse the stored key
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].reload) begin
        pulse_clear();
        load_all(vecs[v].key, vecs[v].tw);
        @(negedge clk);
        check("after_load_load_ready", 64'(load_ready), 64'(0));
        check("after_load_req_ready", 64'(req_ready), 64'(1));
      end
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(vecs[v].exp[i]);
        exp_idx_q.push_back(4'(i));
      end
      request(vecs[v].s);
      wait_drain("vec");
    end

    // back-pressure: ready toggles every cycle, words must hold until accepted
    pulse_clear();
    load_all(vecs[1].key, vecs[1].tw);
    ready_toggle = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(vecs[1].exp[i]);
      exp_idx_q.push_back(4'(i));
    end
    request(5'd0);
    wait_drain("toggle0");
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(vecs[2].exp[i]);
      exp_idx_q.push_back(4'(i));
    end
    request(5'd5);
    wait_drain("toggle5");
    ready_toggle = 1'b0;

    // out-of-range index: single err pulse, no words, then normal service
    err0 = err_cnt;
    request(5'd19);
    repeat (5) @(negedge clk);
    check("err_pulse_count", 64'(err_cnt - err0), 64'(1));
    check("err_req_ready", 64'(req_ready), 64'(1));
    check("err_no_valid", 64'(sk_valid), 64'(0));
    push_model(0);
    request(5'd0);
    wait_drain("after_err");

    // random key, many requests in random order back to back
    pulse_clear();
    load_all({{$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()},
              {$urandom(), $urandom()}}, {{$urandom(), $urandom()}, {$urandom(), $urandom()}});
    for (int r = 0; r < 12; r++) begin
      int s;
      s = $urandom_range(0, NS - 1);
      push_model(s);
      request(5'(s));
    end
    wait_drain("random");

    // clear outputs return to reset values
    @(negedge clk);
    check("pre_clear_req_ready", 64'(req_ready), 64'(1));
    pulse_clear();
    #1;
    check_reset_outputs();

    // reset after word 1 of a stream: abandon the rest
    load_all(vecs[1].key, vecs[1].tw);
    base = sk_cnt;
    push_model(3);
    request(5'd3);
    hit = 1'b0;
    for (int b = 0; b < 50 && !hit; b++) begin
      @(posedge clk); #1;
      hit = (sk_cnt >= base + 2);
    end
    check("mid_reset_reached_word1", 64'(hit), 64'(1));
    in_reset = 1'b1;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    exp_idx_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("in_reset_no_valid", 64'(sk_valid), 64'(0));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    in_reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_reset_no_valid", 64'(sk_valid), 64'(0));
    end
    check_reset_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/threefish_key_schedule.md
THREEFISH_KEY_SCHEDULE -- requirements
Module: threefish_key_schedule

Interface
REQ-001 Parameter NW, default 4, number of key words per block; legal values 4, 8, 16.
REQ-002 Parameter W, default 64, word width in bits.
REQ-003 Parameter NUM_SUBKEYS, default 19, number of legal subkey indices (0..NUM_SUBKEYS-1).
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-low.
REQ-006 clear_i  in  1  synchronous restart to LOAD; discards stored key/tweak.
REQ-007 load_valid_i / load_ready_o  in/out  1/1  load handshake.
REQ-008 load_word_i  in  W  key words 0..NW-1, then tweak words 0..1, in that order.
REQ-009 req_valid_i / req_ready_o  in/out  1/1  subkey request handshake.
REQ-010 req_index_i  in  5  subkey index s.
REQ-011 sk_valid_o / sk_ready_i  out/in  1/1  subkey word stream handshake.
REQ-012 sk_word_o  out  W  subkey word; sk_word_idx_o  out  4  word index i; sk_last_o  out  1  i = NW-1.
REQ-013 err_o  out  1  one-cycle pulse on out-of-range request.

Function
REQ-014 States: LOAD, READY, STREAM; transfer occurs when valid and ready are both high in the same cycle.
REQ-015 LOAD: load_ready_o=1; transfers 0..NW-1 store k[i]; transfers NW and NW+1 store t0 and t1.
REQ-016 Parity word k[NW] = C240 XOR k[0..NW-1], accumulated one word per transfer; t2 = t0 XOR t1, stored on the t1 transfer.
REQ-017 After transfer NW+1: LOAD -> READY next cycle; load_ready_o=0 outside LOAD.
REQ-018 READY: req_ready_o=1; in-range request (s < NUM_SUBKEYS) -> STREAM; sk_valid_o high in the following cycle with i=0.
REQ-019 Out-of-range request: accepted, err_o=1 for one cycle, state stays READY, no words emitted.
REQ-020 Word i of subkey s: k[(s+i) mod (NW+1)] for i < NW-3; + t[s mod 3] for i = NW-3; + t[(s+1) mod 3] for i = NW-2; + s for i = NW-1.
REQ-021 Additions are modulo 2^W; carry-out is discarded.
REQ-022 mod (NW+1) and mod 3 are implemented with wrapping pointers/comparators, no division operator.
REQ-023 sk_word_o, sk_word_idx_o, sk_last_o are registered and held stable while sk_valid_o=1 and sk_ready_i=0.
REQ-024 On a transfer with sk_last_o=1: STREAM -> READY, with req_ready_o=1 in the next cycle; otherwise i increments.
REQ-025 With sk_ready_i held high, one word per cycle; NW words in NW consecutive cycles.
REQ-026 Key and tweak persist across requests; any number of requests in any index order.
REQ-027 clear_i has priority over all transfers in the same cycle; outputs return to reset values in the next cycle.

Reset
REQ-028 rst_i low: state=LOAD, counters=0, k/t registers=0, parity accumulator=C240.
REQ-029 Output values during and after reset: load_ready_o=1, req_ready_o=0, sk_valid_o=0, sk_word_o=0, sk_word_idx_o=0, sk_last_o=0, err_o=0.
REQ-030 Reset mid-stream abandons the subkey with no further sk_valid_o.

Structure
REQ-031 Package threefish_pkg holds C240 = 0x1BD11BDAA9FC1A22 (W=64), the state enum, and the NW legality check.
REQ-032 Sub-module threefish_ks_word computes one subkey word combinationally from k/t selections, s and i.

Verification (NW=4, W=64)
REQ-033 Key all-zero, tweak all-zero, request s=1 -> words 0, 0, 0, 0x1BD11BDAA9FC1A23.
REQ-034 Key 1,2,3,4, tweak 5,6, request s=0 -> 1, 7, 9, 4; request s=5 -> 1, 5, 8, 9 (k and t wrap).
REQ-035 Same key/tweak, sk_ready_i toggled 0/1 every cycle -> same words, each held stable until accepted.
REQ-036 Request s=19 (NUM_SUBKEYS=19) -> err_o pulses once, no sk_valid_o, next request s=0 is served normally.
REQ-037 Key word 3 = 0xFFFFFFFFFFFFFFFF, others 0, tweak 0, request s=2 -> word 3 = k[0]+2 = 2; word 1 = k[3]+0 = 0xFFFFFFFFFFFFFFFF.
REQ-038 rst_i asserted after word 1 of a stream -> all outputs at reset values, load_ready_o=1, no further words.
